// File: rtl/data_sram_bridge.sv
// data_sram_bridge: turns single-cycle CPU M-stage memory accesses into SRAM-like bus transactions, stalling the CPU until done
//   clk, rst (async, active-low)
//   CPU side : memenM, memwrite[3:0], aluoutM[31:0], writedata[31:0] -> readdata[31:0], stall_o
//   bus side : data_req, data_wr, data_size[1:0], data_addr[31:0], data_wdata[31:0]
//              <- data_addr_ok, data_data_ok, data_rdata[31:0]
module data_sram_bridge (
   input  logic        clk,
   input  logic        rst,
   input  logic        memenM,
   input  logic [3:0]  memwrite,
   input  logic [31:0] aluoutM,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        stall_o,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   state_t      state_q, state_d;
   logic        wr_q;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d, wdata_q, rbuf_q;
   logic        cap, rd_ld;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = memenM ? REQ : IDLE;
         REQ:     if (data_addr_ok) state_d = data_data_ok ? DONE : WAIT;
         WAIT:    if (data_data_ok) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      size_d = 2'd2;
      case (memwrite)
         4'b0011, 4'b1100:                   size_d = 2'd1;
         4'b0001, 4'b0010, 4'b0100, 4'b1000: size_d = 2'd0;
         default:                            size_d = 2'd2;
      endcase
   end
   // kseg0/kseg1 map to physical by clearing the top three bits; loads are always word-aligned
   assign addr_d = {(aluoutM[31:30] == 2'b10) ? 3'b000 : aluoutM[31:29], aluoutM[28:2],
                    (|memwrite) ? aluoutM[1:0] : 2'b00};
   assign cap   = (state_q == IDLE) && memenM;
   assign rd_ld = ((state_q == REQ) || (state_q == WAIT)) && data_data_ok && !wr_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rbuf_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         if (cap) begin
            wr_q    <= |memwrite;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= writedata;
         end
         if (rd_ld) rbuf_q <= data_rdata;
      end
   end
   assign data_req   = (state_q == REQ);
   assign data_wr    = wr_q;
   assign data_size  = size_q;
   assign data_addr  = addr_q;
   assign data_wdata = wdata_q;
   assign readdata   = rbuf_q;
   // DONE releases the stall so the CPU advances exactly once per access
   assign stall_o    = memenM && (state_q != DONE);
endmodule

// File: doc/data_sram_bridge.md
DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

Interface
REQ-001 The block SHALL have these ports (name direction width meaning), clock and reset first:
- clk  in  1  the single clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- memenM  in  1  CPU M-stage memory access enable.
- memwrite  in  4  CPU byte-write mask; 0000 = load.
- aluoutM  in  32  CPU virtual data address.
- writedata  in  32  CPU byte-lane-aligned store data.
- readdata  out  32  load word returned to the CPU.
- stall_o  out  1  CPU pipeline stall request.
- data_req  out  1  bus request valid.
- data_wr  out  1  bus write (1) / read (0).
- data_size  out  2  bus size: 0 = byte, 1 = half, 2 = word.
- data_addr  out  32  bus physical address.
- data_wdata  out  32  bus write data.
- data_addr_ok  in  1  bus has accepted the request.
- data_data_ok  in  1  bus read data valid, or bus write complete.
- data_rdata  in  32  bus read data.
REQ-002 The block SHALL have no parameters.

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT and DONE, held in a registered state variable.
REQ-004 IDLE: if memenM=1, the block SHALL capture the request registers and go to REQ next cycle; otherwise it SHALL stay in IDLE.
REQ-005 REQ: data_req SHALL be 1.
- addr_ok=1 and data_ok=1 -> DONE.
- addr_ok=1 only -> WAIT.
- otherwise stay in REQ.
REQ-006 WAIT: data_req SHALL be 0; data_ok=1 -> DONE, otherwise stay in WAIT.
REQ-007 DONE: the block SHALL go unconditionally to IDLE; it SHALL NOT re-issue the access even though memenM is still 1 in this cycle.
REQ-008 data_req SHALL be 1 only in REQ, and it SHALL be a registered-state decode with no combinational path from the bus inputs.
REQ-009 Request registers SHALL be captured only on the IDLE->REQ transition and held stable until the FSM returns to IDLE.
REQ-010 Captured data_wr SHALL equal |memwrite.
REQ-011 Captured data_size:
- memwrite 1111 or 0000 -> 2.
- memwrite 0011 or 1100 -> 1.
- one-hot memwrite -> 0.
- any other mask -> 2.
REQ-012 Captured data_addr:
- low 2 bits: aluoutM[1:0] for stores, 00 for loads.
- bits [31:29]: 000 when aluoutM[31:30]=10 (kseg0/kseg1), otherwise aluoutM[31:29].
- bits [28:2]: aluoutM[28:2].
REQ-013 Captured data_wdata SHALL equal writedata, unmodified.
REQ-014 The read buffer SHALL load data_rdata when data_ok=1 in REQ or WAIT and data_wr=0; readdata SHALL be the read buffer.
REQ-015 The read buffer SHALL hold its value otherwise; writes SHALL NOT modify it.
REQ-016 stall_o SHALL equal memenM AND (state != DONE), combinationally.
REQ-017 Minimum latency SHALL be 3 cycles from memenM rising in IDLE to stall_o=0 (IDLE, REQ with addr_ok and data_ok, DONE).
REQ-018 Each extra cycle without addr_ok or data_ok SHALL add exactly one stall cycle.
REQ-019 data_ok seen in IDLE or DONE, and addr_ok seen outside REQ, SHALL be ignored.
REQ-020 Back-to-back accesses: after DONE, the next memenM SHALL be honoured in the following IDLE cycle, with no lost or duplicated transaction.

Reset
REQ-021 When rst=0, the block SHALL immediately force: state=IDLE, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, read buffer=0.
REQ-022 A reset mid-transaction (REQ or WAIT) SHALL abandon the access; data_ok arriving after reset release SHALL be ignored per REQ-019.

Verification
REQ-023 Load: aluoutM=0x8000_1006, memwrite=0000, memenM=1; addr_ok and data_ok in the first REQ cycle, data_rdata=0x1234_5678 -> data_addr=0x0000_1004, size=2, wr=0; stall_o high 2 cycles; readdata=0x1234_5678 in DONE.
REQ-024 Byte store: aluoutM=0xBFC0_0003, memwrite=1000, writedata=0xAB00_0000 -> data_addr=0x1FC0_0003, size=0, wr=1, data_wdata=0xAB00_0000; readdata unchanged.
REQ-025 Back-pressure: addr_ok delayed 3 cycles, then data_ok delayed 2 cycles -> data_req high exactly 4 cycles; address stable throughout; stall_o high 7 cycles; exactly one transaction.
REQ-026 Back-to-back: halfword store (memwrite=1100, address 0x0000_0042) then load in consecutive instructions -> two bus requests, sizes 1 then 2; DONE never re-issues.
REQ-027 Reset: rst=0 while in WAIT -> data_req=0, state=IDLE, readdata=0 in the same cycle; a stray data_ok after release is ignored.
REQ-028 Idle: memenM=0 for 10 cycles with random addr_ok/data_ok toggling -> data_req=0 and stall_o=0 throughout.
